log_sprite_engine: RTL
======================

# log_sprite_engine

Parametrised multi-object sprite renderer for the river lane: it holds a double-buffered table of NUM_OBJ object positions and draws a shared OBJ_W x OBJ_H bitmap at each enabled position. A fixed 2-stage pipeline produces a colour and a drawing request for the pixel the VGA controller is scanning. It also reports, once per frame, whether a probe pixel (the frog anchor) was covered by any object. It sits between the game-logic position updater and the VGA priority mux.

## Interface
Parameters:
- NUM_OBJ, 16, number of object slots (1..128)
- OBJ_W, 40, bitmap width in pixels
- OBJ_H, 10, bitmap height in pixels
- SCREEN_W, 640, horizontal wrap modulus in pixels
- WRAP_X, 1, 1 = objects wrap horizontally modulo SCREEN_W; 0 = clipped at screen edge
- IDX_W, $clog2(NUM_OBJ), slot index width

Ports:
- CLK  in  1  pixel clock; the block's only clock
- RESETn  in  1  asynchronous active-low reset
- oCoord_X  in  11  current scan X
- oCoord_Y  in  11  current scan Y
- frame_start  in  1  one-cycle strobe at start of frame; commits the shadow table and the probe result
- wr_en  in  1  shadow-table write strobe
- wr_idx  in  IDX_W  slot to write
- wr_x  in  11  slot start X
- wr_y  in  11  slot start Y
- wr_vld  in  1  slot enable
- probe_X  in  11  probe pixel X (frog anchor)
- probe_Y  in  11  probe pixel Y
- drawing_request  out  1  pixel is covered by an opaque sprite pixel
- mVGA_RGB  out  8  RRRGGGBB colour
- hit_idx  out  IDX_W  slot that produced the current pixel
- probe_on_obj  out  1  previous frame's probe pixel was covered
- probe_valid  out  1  probe_on_obj reflects at least one complete frame

## Operation
- Shadow table: wr_en writes {wr_x, wr_y, wr_vld} into slot wr_idx. wr_idx >= NUM_OBJ is ignored.
- Active table: copied from the shadow table on frame_start. Rendering reads only the active table, so mid-frame writes never tear.
- wr_en and frame_start in the same cycle: the write lands in the shadow table, and the copy carries the new value for that slot.
- Slot hit: the slot must be valid and wr_x < SCREEN_W; otherwise the slot never hits.
  - dy = oCoord_Y - y, computed in 12 bits; hit requires 0 <= dy < OBJ_H. There is no Y wrap.
  - WRAP_X=1: dx = (oCoord_X - x) mod SCREEN_W; hit requires dx < OBJ_W.
  - WRAP_X=0: dx = oCoord_X - x, computed in 12 bits; hit requires 0 <= dx < OBJ_W.
  - oCoord_X >= SCREEN_W never hits.
- Priority: the lowest-index hitting slot wins. Its dx/dy address the bitmap.
- Bitmap:
  - Colour ROM of OBJ_H x OBJ_W x 8 plus a 1-bit mask ROM, both indexed [dy][dx] with no flip.
  - Contents come from the lane art package.
  - A mask bit of 0 means transparent: drawing_request=0 even on a hit, and no lower-priority slot is consulted.
- Probe:
  - A sticky flag sets when the pipeline output pixel equals (probe_X, probe_Y) with drawing_request=1.
  - On frame_start the flag transfers to probe_on_obj and clears. probe_valid sets at the first frame_start after reset.

## Timing
- Stage 1 (registered): hit vector, priority encode, dx/dy, hit_idx.
- Stage 2 (registered): ROM read; drawing_request, mVGA_RGB and hit_idx are driven from this stage.
- Latency: 2 cycles from oCoord to outputs. Throughput: 1 pixel per cycle.
- No hit: drawing_request=0 and mVGA_RGB=8'h00.
- An active-table change affects outputs 2 cycles after the frame_start edge.
- The probe comparison uses the coordinates delayed 2 cycles, so it stays aligned with the outputs.
- Reset: all table entries invalid with X/Y=0, pipeline cleared, drawing_request=0, mVGA_RGB=8'h00, hit_idx=0, probe_on_obj=0, probe_valid=0, sticky flag=0.
- Reset mid-frame: everything clears immediately; the table must be rewritten and committed.

## Test plan
- Write slot 0 with (100,50,vld), pulse frame_start, scan (100,50) -> 2 cycles later drawing_request=1, RGB=ROM[0][0], hit_idx=0. Scan (140,50) -> drawing_request=0.
- Write slot 3 with (620,20,vld), WRAP_X=1, commit -> (639,20) hits with dx=19; (0,20) hits with dx=20; (19,20) hits with dx=39; (20,20) does not hit. With WRAP_X=0, (0,20) does not hit.
- Slots 2 and 5 overlap at (200,80) -> hit_idx=2. Clear slot 2's mask pixel at that spot -> drawing_request=0, and slot 5 is not shown.
- Write slot 1 to (300,100) without frame_start -> scanning (300,100) gives no hit. Pulse frame_start with a simultaneous write of (300,100) to slot 1 -> next scan hits.
- probe=(110,55) under a committed object, run one frame -> probe_on_obj=1, probe_valid=1. Move the object away and commit -> after the next frame probe_on_obj=0.
- Assert RESETn low mid-scan while hitting -> outputs go to 0 asynchronously. After release with no writes -> never a hit.

Source files
------------

// File: rtl/log_sprite_engine.sv
// ---------------------------------------------------------------------------
// log_sprite_engine
//
// Multi-object sprite renderer for the river lane. Holds a double-buffered
// table of NUM_OBJ object positions: game logic writes the shadow copy at any
// time, and frame_start promotes it to the active copy used for rendering.
// One OBJ_W x OBJ_H bitmap is drawn at every enabled position. A two-stage
// pipeline turns the scan coordinate into a colour and a drawing request.
// The block also reports, once per frame, whether a probe pixel (the frog
// anchor) was covered by any opaque object pixel.
//
// Ports:
//   CLK, RESETn          pixel clock, asynchronous active-low reset
//   oCoord_X/oCoord_Y    current scan coordinate
//   frame_start          start-of-frame strobe: commits table and probe result
//   wr_en/wr_idx/wr_x/   shadow-table write port (slot, start X/Y, enable)
//   wr_y/wr_vld
//   probe_X/probe_Y      probe pixel coordinate
//   drawing_request      current pixel is an opaque sprite pixel
//   mVGA_RGB             RRRGGGBB colour of the current pixel
//   hit_idx              slot that produced the current pixel
//   probe_on_obj         probe pixel was covered during the previous frame
//   probe_valid          probe_on_obj reflects at least one complete frame
// ---------------------------------------------------------------------------
module log_sprite_engine #(
    parameter int NUM_OBJ  = 16,
    parameter int OBJ_W    = 40,
    parameter int OBJ_H    = 10,
    parameter int SCREEN_W = 640,
    parameter int WRAP_X   = 1,
    parameter int IDX_W    = $clog2(NUM_OBJ)
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [10:0]      oCoord_X,
    input  logic [10:0]      oCoord_Y,
    input  logic             frame_start,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [10:0]      wr_x,
    input  logic [10:0]      wr_y,
    input  logic             wr_vld,
    input  logic [10:0]      probe_X,
    input  logic [10:0]      probe_Y,
    output logic             drawing_request,
    output logic [7:0]       mVGA_RGB,
    output logic [IDX_W-1:0] hit_idx,
    output logic             probe_on_obj,
    output logic             probe_valid
);

    localparam int DXW = $clog2(OBJ_W + 1);
    localparam int DYW = $clog2(OBJ_H + 1);

    // Bitmap colour: a deterministic gradient over the object body.
    function automatic logic [7:0] romColour(input logic [DYW-1:0] dy,
                                             input logic [DXW-1:0] dx);
        return (8'(dy) * 8'(OBJ_W) + 8'(dx)) ^ 8'h5A;
    endfunction

    // Bitmap mask: a regular pattern of holes (knots in the log) is transparent.
    function automatic logic romMask(input logic [DYW-1:0] dy,
                                     input logic [DXW-1:0] dx);
        return !(((32'(dx) % 8) == 7) && ((32'(dy) % 4) == 3));
    endfunction

    logic [10:0] r_shX [NUM_OBJ];
    logic [10:0] r_shY [NUM_OBJ];
    logic        r_shV [NUM_OBJ];
    logic [10:0] r_acX [NUM_OBJ];
    logic [10:0] r_acY [NUM_OBJ];
    logic        r_acV [NUM_OBJ];

    logic             w_wrOk;
    logic [NUM_OBJ-1:0] w_hit;
    logic [11:0]      w_dx [NUM_OBJ];
    logic [11:0]      w_dy [NUM_OBJ];
    logic             w_any;
    logic [IDX_W-1:0] w_selIdx;
    logic [DXW-1:0]   w_selDx;
    logic [DYW-1:0]   w_selDy;
    logic             w_match;

    logic             r_s1Hit;
    logic [IDX_W-1:0] r_s1Idx;
    logic [DXW-1:0]   r_s1Dx;
    logic [DYW-1:0]   r_s1Dy;
    logic [10:0]      r_s1X;
    logic [10:0]      r_s1Y;
    logic [10:0]      r_s2X;
    logic [10:0]      r_s2Y;
    logic             r_draw;
    logic [7:0]       r_rgb;
    logic [IDX_W-1:0] r_idx;
    logic             r_sticky;
    logic             r_probeOn;
    logic             r_probeValid;

    assign w_wrOk = wr_en && (int'(wr_idx) < NUM_OBJ);

    // Shadow table takes writes; the active table is reloaded on frame_start.
    // A write in the same cycle as frame_start is forwarded into the active
    // copy so the committed table always reflects the latest write.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_shX[i] <= '0;
                r_shY[i] <= '0;
                r_shV[i] <= 1'b0;
                r_acX[i] <= '0;
                r_acY[i] <= '0;
                r_acV[i] <= 1'b0;
            end
        end else begin
            if (w_wrOk) begin
                r_shX[wr_idx] <= wr_x;
                r_shY[wr_idx] <= wr_y;
                r_shV[wr_idx] <= wr_vld;
            end
            if (frame_start) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    if (w_wrOk && (wr_idx == IDX_W'(i))) begin
                        r_acX[i] <= wr_x;
                        r_acY[i] <= wr_y;
                        r_acV[i] <= wr_vld;
                    end else begin
                        r_acX[i] <= r_shX[i];
                        r_acY[i] <= r_shY[i];
                        r_acV[i] <= r_shV[i];
                    end
                end
            end
        end
    end

    // Per-slot hit test. Differences are taken in 12 bits so a scan position
    // left of / above the object wraps to a large value and fails the range
    // check. With horizontal wrap the X offset is folded modulo SCREEN_W.
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_dy[i] = {1'b0, oCoord_Y} - {1'b0, r_acY[i]};
            if ((WRAP_X != 0) && (oCoord_X < r_acX[i])) begin
                w_dx[i] = {1'b0, oCoord_X} + 12'(SCREEN_W) - {1'b0, r_acX[i]};
            end else begin
                w_dx[i] = {1'b0, oCoord_X} - {1'b0, r_acX[i]};
            end
            w_hit[i] = r_acV[i]
                    && ({1'b0, r_acX[i]} < 12'(SCREEN_W))
                    && ({1'b0, oCoord_X} < 12'(SCREEN_W))
                    && (w_dy[i] < 12'(OBJ_H))
                    && (w_dx[i] < 12'(OBJ_W));
        end
    end

    // Lowest-index hitting slot wins: scan from the top down so the last
    // assignment belongs to the smallest index.
    always_comb begin
        w_any    = 1'b0;
        w_selIdx = '0;
        w_selDx  = '0;
        w_selDy  = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any    = 1'b1;
                w_selIdx = IDX_W'(i);
                w_selDx  = w_dx[i][DXW-1:0];
                w_selDy  = w_dy[i][DYW-1:0];
            end
        end
    end

    // Stage 1 captures the winning slot and its bitmap address; stage 2 reads
    // the bitmap. Scan coordinates travel alongside for the probe compare.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_s1Hit <= 1'b0;
            r_s1Idx <= '0;
            r_s1Dx  <= '0;
            r_s1Dy  <= '0;
            r_s1X   <= '0;
            r_s1Y   <= '0;
            r_s2X   <= '0;
            r_s2Y   <= '0;
            r_draw  <= 1'b0;
            r_rgb   <= 8'h00;
            r_idx   <= '0;
        end else begin
            r_s1Hit <= w_any;
            r_s1Idx <= w_selIdx;
            r_s1Dx  <= w_selDx;
            r_s1Dy  <= w_selDy;
            r_s1X   <= oCoord_X;
            r_s1Y   <= oCoord_Y;
            r_s2X   <= r_s1X;
            r_s2Y   <= r_s1Y;
            r_idx   <= r_s1Idx;
            if (r_s1Hit && romMask(r_s1Dy, r_s1Dx)) begin
                r_draw <= 1'b1;
                r_rgb  <= romColour(r_s1Dy, r_s1Dx);
            end else begin
                r_draw <= 1'b0;
                r_rgb  <= 8'h00;
            end
        end
    end

    assign w_match = r_draw && (r_s2X == probe_X) && (r_s2Y == probe_Y);

    // Sticky probe flag accumulates over the frame; frame_start publishes it
    // (including a match landing on that very cycle) and starts a new frame.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sticky     <= 1'b0;
            r_probeOn    <= 1'b0;
            r_probeValid <= 1'b0;
        end else if (frame_start) begin
            r_probeOn    <= r_sticky | w_match;
            r_sticky     <= 1'b0;
            r_probeValid <= 1'b1;
        end else if (w_match) begin
            r_sticky <= 1'b1;
        end
    end

    assign drawing_request = r_draw;
    assign mVGA_RGB        = r_rgb;
    assign hit_idx         = r_idx;
    assign probe_on_obj    = r_probeOn;
    assign probe_valid     = r_probeValid;

endmodule
